// File: rtl/dvi_timing_gen.sv
// DVI raster timing generator: pixel coordinates, data enable, syncs and
// a one-cycle-ahead pixel request for the TMDS encoder channels.
module dvi_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        pix_req
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_next_c;
  logic [11:0] v_next_c;
  logic        de_next_c;
  logic        hsync_next_c;
  logic        vsync_next_c;
  logic        line_start_next_c;
  logic        frame_start_next_c;

  // Next raster position; a low enable parks the counters in the idle corner
  always_comb begin
    h_next_c = H_LAST;
    v_next_c = V_LAST;
    if (enable) begin
      if (hcount != H_LAST) begin
        h_next_c = hcount + 12'd1;
        v_next_c = vcount;
      end else begin
        h_next_c = '0;
        v_next_c = (vcount == V_LAST) ? '0 : vcount + 12'd1;
      end
    end
  end

  // Region decode on the next position so registered controls align with the counters
  always_comb begin
    de_next_c          = enable && (h_next_c < H_ACT_END) && (v_next_c < V_ACT_END);
    hsync_next_c       = ((h_next_c >= H_SYNC_BEG) && (h_next_c < H_SYNC_END))
                         ? HSYNC_POL : ~HSYNC_POL;
    vsync_next_c       = ((v_next_c >= V_SYNC_BEG) && (v_next_c < V_SYNC_END))
                         ? VSYNC_POL : ~VSYNC_POL;
    line_start_next_c  = enable && (h_next_c == '0);
    frame_start_next_c = line_start_next_c && (v_next_c == '0);
  end

  // Pixel request looks one edge ahead so a single-register source lines up with de
  assign pix_req = ~reset & de_next_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next_c;
      vcount      <= v_next_c;
      de          <= de_next_c;
      hsync       <= hsync_next_c;
      vsync       <= vsync_next_c;
      line_start  <= line_start_next_c;
      frame_start <= frame_start_next_c;
    end
  end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Self-checking bench for dvi_timing_gen on a 15x8 raster, using a linear
// pixel-index reference model.
module tb_dvi_timing_gen;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] hcount, vcount;
  logic        de, hsync, vsync, line_start, frame_start, pix_req;

  int tests = 0;
  int fails = 0;

  // Reference state: linear index into the frame, idle corner is FT-1
  int m_idx = FT - 1;
  bit m_ls  = 1'b0;

  dvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .hcount(hcount), .vcount(vcount), .de(de), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .pix_req(pix_req)
  );

  always #5 clk = ~clk;

  function automatic logic m_de(input int i);
    return ((i % HT) < 8) && ((i / HT) < 4);
  endfunction

  function automatic logic m_hsync(input int i);
    return !(((i % HT) >= 10) && ((i % HT) < 13));
  endfunction

  function automatic logic m_vsync(input int i);
    return !(((i / HT) >= 5) && ((i / HT) < 7));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (model idx %0d)", tag, obs, exp, m_idx);
    end
  endtask

  task automatic check_outputs();
    chk("hcount", 16'(hcount), 16'(m_idx % HT));
    chk("vcount", 16'(vcount), 16'(m_idx / HT));
    chk("de", 16'(de), 16'(m_de(m_idx)));
    chk("hsync", 16'(hsync), 16'(m_hsync(m_idx)));
    chk("vsync", 16'(vsync), 16'(m_vsync(m_idx)));
    chk("line_start", 16'(line_start), 16'(m_ls));
    chk("frame_start", 16'(frame_start), 16'(m_ls && (m_idx == 0)));
  endtask

  // One clock: drive enable at the falling edge, check pix_req, then advance
  task automatic step(input logic en);
    @(negedge clk);
    enable = en;
    #1;
    chk("pix_req", 16'(pix_req), 16'(en && m_de((m_idx + 1) % FT)));
    @(posedge clk);
    if (en) begin
      m_idx = (m_idx + 1) % FT;
      m_ls  = ((m_idx % HT) == 0);
    end else begin
      m_idx = FT - 1;
      m_ls  = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse placed between edges
  task automatic reset_pulse();
    #2;
    reset = 1'b1;
    #1;
    m_idx = FT - 1;
    m_ls  = 1'b0;
    check_outputs();
    chk("pix_req_in_reset", 16'(pix_req), 16'd0);
    reset = 1'b0;
  endtask

  initial begin
    int fs_prev;
    int vlow;
    int lines;
    int guard;

    // Reset held with enable high
    repeat (2) @(posedge clk);
    #2;
    check_outputs();
    chk("pix_req_in_reset", 16'(pix_req), 16'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("pix_req_after_release", 16'(pix_req), 16'd1);

    // Two full frames: periods and vsync width
    fs_prev = -1;
    vlow    = 0;
    lines   = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step(1'b1);
      if (i == 0) chk("first_frame_start", 16'(frame_start), 16'd1);
      if (frame_start) begin
        if (fs_prev >= 0) chk("frame_period", 16'(i - fs_prev), 16'(FT));
        fs_prev = i;
      end
      if (!vsync) vlow++;
      if (line_start) lines++;
    end
    chk("vsync_low_cycles", 16'(vlow), 16'(2 * 30));
    chk("line_starts", 16'(lines), 16'(2 * VT));

    // Disable at (3,2), then re-enable
    guard = 0;
    while (m_idx != 2 * HT + 3 && guard < 2 * FT) begin
      step(1'b1);
      guard++;
    end
    chk("reach_3_2", 16'(m_idx), 16'(2 * HT + 3));
    step(1'b0);
    chk("disable_h", 16'(hcount), 16'd14);
    chk("disable_v", 16'(vcount), 16'd7);
    step(1'b1);
    chk("reenable_fs", 16'(frame_start), 16'd1);

    // Reset asserted in the middle of vsync at (11,5)
    guard = 0;
    while (m_idx != 5 * HT + 11 && guard < 2 * FT) begin
      step(1'b1);
      guard++;
    end
    chk("reach_11_5", 16'(m_idx), 16'(5 * HT + 11));
    reset_pulse();
    chk("reset_async_h", 16'(hcount), 16'd14);
    step(1'b1);
    chk("resume_fs", 16'(frame_start), 16'd1);

    // Randomized enable drops and occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 49) == 0) reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dvi_timing_gen.md
# dvi_timing_gen

Video timing controller that sequences the three TMDS encoder channels of the DVI transmitter. It generates pixel coordinates, data enable, and hsync/vsync, which drive the encoders' `de`/`c0`/`c1`. It also issues a one-cycle-ahead pixel request to the frame/pixel source. It runs in the pixel clock domain, and every encoder channel consumes its outputs in the same cycle.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `HSYNC_POL`, default 0: hsync asserted level (0 = active-low).
- `VSYNC_POL`, default 0: vsync asserted level (0 = active-low).
- Legality: every parameter is ≥1. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP ≤ 4096. V_TOTAL = sum of the V_* parameters ≤ 4096.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run timing; when low, hold in idle.
- `hcount`  out  12  current horizontal position.
- `vcount`  out  12  current line.
- `de`  out  1  active video; goes to the encoder `de`.
- `hsync`  out  1  goes to blue-channel `c0`.
- `vsync`  out  1  goes to blue-channel `c1`.
- `line_start`  out  1  one-cycle pulse at hcount==0.
- `frame_start`  out  1  one-cycle pulse at (0,0).
- `pix_req`  out  1  the next cycle is an active pixel.

## Operation
- Position state is the (hcount, vcount) register pair.
- Idle position is (H_TOTAL-1, V_TOTAL-1), which lies in the back porch of both axes.
- Next position when `enable`=1:
  - hcount+1 if hcount < H_TOTAL-1.
  - Otherwise hcount→0, and vcount advances: vcount+1, or wraps to 0 from V_TOTAL-1.
- Next position when `enable`=0: idle position, regardless of the current position.
- Horizontal regions, decoded from hcount:
  - ACTIVE: [0, H_ACTIVE).
  - FRONT: [H_ACTIVE, H_ACTIVE+H_FP).
  - SYNC: [H_ACTIVE+H_FP, +H_SYNC).
  - BACK: the remainder.
- Vertical regions are defined identically on vcount, using the V_* parameters.
- `de` = horizontal ACTIVE and vertical ACTIVE.
- `hsync` = HSYNC_POL when in horizontal SYNC, otherwise ~HSYNC_POL.
- `vsync` = VSYNC_POL when in vertical SYNC, otherwise ~VSYNC_POL. vsync spans whole lines, changing only when hcount transitions to 0.
- `line_start` = (hcount==0) and the position was entered by advancing, not by holding idle.
- `frame_start` = line_start and (vcount==0).
- `de`, `hsync`, `vsync`, `line_start`, `frame_start` are registers. Each is computed from the next position, so it is aligned with `hcount`/`vcount` in the same cycle.
- `pix_req` is combinational. It equals the `de` value that will be registered at the next edge, including the `enable` gate. It is forced 0 while `reset` is high.
- Disable mid-frame: at the next edge the block jumps to the idle position. `de`=0 and both syncs are inactive. No partial sync pulse is stretched.
- Re-enable from idle: the next edge lands on (0,0) with `de`=1, `line_start`=1, `frame_start`=1.

## Timing
- Reset values (applied asynchronously):
  - hcount = H_TOTAL-1, vcount = V_TOTAL-1.
  - de = 0, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - line_start = 0, frame_start = 0, pix_req = 0.
- Reset deassertion takes effect at the first rising edge after release. With `enable`=1 at that edge, the cycle after it shows (0,0).
- Latency:
  - Coordinates and control outputs: 0 cycles relative to each other.
  - `pix_req` leads `de` by exactly 1 cycle, so a pixel source with 1 registered stage lines up with `de`.
  - Downstream encoders add 1 cycle uniformly to all channels.
- Periods:
  - Line: H_TOTAL cycles.
  - Frame: H_TOTAL×V_TOTAL cycles.
  - `frame_start` occurs once per frame; `line_start` occurs once per line, including blanking lines.
- `enable` is sampled every edge. A 1-cycle low pulse forces the idle position and restarts the frame.

## Test plan
Test parameters: H = 8/2/3/2 (H_TOTAL 15); V = 4/1/2/1 (V_TOTAL 8); polarities 0.
- Reset with `enable`=1:
  - During reset, outputs hold the reset values above and pix_req = 0.
  - After release and before the first edge, pix_req = 1.
  - At the first edge: (0,0), de = 1, line_start = 1, frame_start = 1.
- Line scan:
  - de is high for hcount 0–7.
  - hsync is low exactly at hcount 10–12.
  - line_start occurs every 15 cycles.
  - pix_req is high at hcount 14 (on lines 7, 0–2) and at hcount 0–6; it is low at hcount 7.
- Vertical:
  - vsync is low for exactly 30 cycles, from (0,5) through (14,6).
  - de is 0 on every line with vcount 4–7.
  - hcount wraps 14→0 while vcount increments.
- Frame:
  - frame_start recurs every 120 cycles.
  - vcount wraps 7→0 only on the edge where hcount wraps.
- Disable at position (3,2):
  - Next cycle: (14,7), de = 0, hsync = vsync = 1, pix_req = 0.
  - Re-enable: the next cycle is (0,0) with frame_start = 1.
- Reset mid-sync:
  - Assert reset at (11,5) between clock edges.
  - All outputs go to reset values immediately, with no edge needed.
  - After release, the block resumes at (0,0).
